muldiv_sequencer: RTL and testbench

- Sequences the shared multiplier and divisor units and the HI/LO register pair on behalf of the main control FSM.
- Accepts one mult/div request and pulses the matching start signal. Waits for that unit's completion, then drives the HI/LO source selects and write enables for exactly one cycle.
- Reports completion, divide-by-zero and (optionally) timeout to the main control FSM, which uses them to leave its wait state or branch to exception handling.

---
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divisor and the HI/LO write for the main control FSM.
// Optional WAIT-state timeout is compiled in with `define MULDIV_TIMEOUT_EN.
module muldiv_sequencer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             op_div,
    input  logic             mult_fim,
    input  logic             div_fim,
    input  logic             div_zero,
    output logic             mult_start,
    output logic             div_start,
    output logic             hi_sel,
    output logic             lo_sel,
    output logic             hi_write,
    output logic             lo_write,
    output logic             busy,
    output logic             done,
    output logic             exc_div0,
    output logic             exc_timeout,
    output logic [CNT_W-1:0] last_latency
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_WRITE,
        ST_DONE,
        ST_EXC
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_timeout_range
        $error("muldiv_sequencer: TIMEOUT must be in 1 .. 2**CNT_W-1");
    end

    state_t           state, next_state;
    logic             kind_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             fim_sel;
    logic             div0_hit;
    logic             timeout_hit;

    assign fim_sel  = kind_r ? div_fim : mult_fim;
    assign div0_hit = kind_r & div_zero;
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef MULDIV_TIMEOUT_EN
    logic cause_timeout_r;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: next_state gets its default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (op_valid) next_state = ST_START;
            ST_START: next_state = ST_WAIT;
            ST_WAIT: begin
                if (div0_hit)         next_state = ST_EXC;
                else if (fim_sel)     next_state = ST_WRITE;
                else if (timeout_hit) next_state = ST_EXC;
            end
            ST_WRITE: next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            ST_EXC:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            kind_r       <= 1'b0;
            cnt          <= '0;
            last_latency <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && op_valid) begin
                kind_r <= op_div;
                cnt    <= '0;
            end
            if (state == ST_WAIT) begin
                cnt <= cnt_inc;
                if (next_state == ST_WRITE) last_latency <= cnt_inc;
            end
        end
    end

`ifdef MULDIV_TIMEOUT_EN
    // Cause is captured on the WAIT->EXC edge; div_zero outranks timeout there.
    always_ff @(posedge clock) begin
        if (reset) begin
            cause_timeout_r <= 1'b0;
        end else if (state == ST_WAIT && next_state == ST_EXC) begin
            cause_timeout_r <= ~div0_hit;
        end
    end
`endif

    always_comb begin
        mult_start  = 1'b0;
        div_start   = 1'b0;
        hi_write    = 1'b0;
        lo_write    = 1'b0;
        done        = 1'b0;
        exc_div0    = 1'b0;
        exc_timeout = 1'b0;
        busy        = (state != ST_IDLE);
        hi_sel      = busy & kind_r;
        lo_sel      = busy & kind_r;
        case (state)
            ST_START: begin
                mult_start = ~kind_r;
                div_start  = kind_r;
            end
            ST_WRITE: begin
                hi_write = 1'b1;
                lo_write = 1'b1;
            end
            ST_DONE: done = 1'b1;
            ST_EXC: begin
`ifdef MULDIV_TIMEOUT_EN
                exc_div0    = ~cause_timeout_r;
                exc_timeout = cause_timeout_r;
`else
                exc_div0    = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; inputs change 1 ns after each rising
// edge and outputs are checked there, well away from the next active edge.
module tb_muldiv_sequencer;

    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             op_valid;
    logic             op_div;
    logic             mult_fim;
    logic             div_fim;
    logic             div_zero;
    logic             mult_start;
    logic             div_start;
    logic             hi_sel;
    logic             lo_sel;
    logic             hi_write;
    logic             lo_write;
    logic             busy;
    logic             done;
    logic             exc_div0;
    logic             exc_timeout;
    logic [CNT_W-1:0] last_latency;

    int tests_run = 0;
    int tests_failed = 0;

    muldiv_sequencer #(.CNT_W(CNT_W), .TIMEOUT(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_div       (op_div),
        .mult_fim     (mult_fim),
        .div_fim      (div_fim),
        .div_zero     (div_zero),
        .mult_start   (mult_start),
        .div_start    (div_start),
        .hi_sel       (hi_sel),
        .lo_sel       (lo_sel),
        .hi_write     (hi_write),
        .lo_write     (lo_write),
        .busy         (busy),
        .done         (done),
        .exc_div0     (exc_div0),
        .exc_timeout  (exc_timeout),
        .last_latency (last_latency)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Packs the ten 1-bit outputs so a whole-state check is a single comparison.
    function automatic logic [31:0] flags();
        return {22'd0, mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write,
                busy, done, exc_div0, exc_timeout};
    endfunction

    // Bit positions inside flags()
    localparam logic [31:0] F_MS = 32'h200, F_DS = 32'h100, F_HS = 32'h080, F_LS = 32'h040,
                            F_HW = 32'h020, F_LW = 32'h010, F_BUSY = 32'h008, F_DONE = 32'h004,
                            F_DIV0 = 32'h002, F_TO = 32'h001;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_div = 1'b0;
        mult_fim = 1'b0; div_fim = 1'b0; div_zero = 1'b0;
        tick(); tick();
        chk("reset_flags", flags(), 32'h0);
        chk("reset_latency", last_latency, 32'd0);
        reset = 1'b0;

        // Mult path, mult_fim on the 5th WAIT cycle
        op_valid = 1'b1; op_div = 1'b0;
        tick();
        chk("mult_start", flags(), F_MS | F_BUSY);
        op_valid = 1'b0;
        tick();
        chk("mult_wait1", flags(), F_BUSY);
        tick(); tick(); tick();
        chk("mult_wait4", flags(), F_BUSY);
        tick();
        chk("mult_wait5", flags(), F_BUSY);
        mult_fim = 1'b1;
        tick();
        chk("mult_write", flags(), F_HW | F_LW | F_BUSY);
        mult_fim = 1'b0;
        tick();
        chk("mult_done", flags(), F_DONE | F_BUSY);
        chk("mult_latency", last_latency, 32'd5);
        tick();
        chk("mult_idle", flags(), 32'h0);

        // Div path, div_fim held from START: done 4 edges after the request edge
        op_valid = 1'b1; op_div = 1'b1;
        tick();
        chk("div_start", flags(), F_DS | F_HS | F_LS | F_BUSY);
        op_valid = 1'b0; div_fim = 1'b1;
        tick();
        chk("div_wait", flags(), F_HS | F_LS | F_BUSY);
        tick();
        chk("div_write", flags(), F_HW | F_LW | F_HS | F_LS | F_BUSY);
        tick();
        chk("div_done", flags(), F_DONE | F_HS | F_LS | F_BUSY);
        chk("div_latency", last_latency, 32'd1);
        div_fim = 1'b0;
        tick();
        chk("div_idle", flags(), 32'h0);

        // Divide by zero together with div_fim: exception wins, latency kept
        op_valid = 1'b1; op_div = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        chk("div0_wait2", flags(), F_HS | F_LS | F_BUSY);
        div_zero = 1'b1; div_fim = 1'b1;
        tick();
        chk("div0_exc", flags(), F_DIV0 | F_HS | F_LS | F_BUSY);
        chk("div0_latency", last_latency, 32'd1);
        div_zero = 1'b0; div_fim = 1'b0;
        tick();
        chk("div0_idle", flags(), 32'h0);

        // Ignored inputs: op_valid while busy, mult_fim during a div
        op_valid = 1'b1; op_div = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        op_valid = 1'b1; op_div = 1'b0; mult_fim = 1'b1;
        tick();
        chk("ign_wait2", flags(), F_HS | F_LS | F_BUSY);
        op_valid = 1'b0;
        tick();
        chk("ign_wait3", flags(), F_HS | F_LS | F_BUSY);
        mult_fim = 1'b0; div_fim = 1'b1;
        tick();
        chk("ign_write", flags(), F_HW | F_LW | F_HS | F_LS | F_BUSY);
        div_fim = 1'b0;
        tick();
        chk("ign_done", flags(), F_DONE | F_HS | F_LS | F_BUSY);
        chk("ign_latency", last_latency, 32'd3);
        tick();
        chk("ign_idle", flags(), 32'h0);

        // Reset in the middle of WAIT
        op_valid = 1'b1; op_div = 1'b0;
        tick();
        op_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_flags", flags(), 32'h0);
        chk("rst_mid_latency", last_latency, 32'd0);
        reset = 1'b0; mult_fim = 1'b1;
        tick();
        chk("rst_late_fim1", flags(), 32'h0);
        tick();
        chk("rst_late_fim2", flags(), 32'h0);
        mult_fim = 1'b0;

`ifdef MULDIV_TIMEOUT_EN
        // No fim: exc_timeout in the cycle after the 64th WAIT cycle
        op_valid = 1'b1; op_div = 1'b0;
        tick();
        op_valid = 1'b0;
        tick();
        for (int i = 2; i <= 64; i++) tick();
        chk("to_wait64", flags(), F_BUSY);
        tick();
        chk("to_exc", flags(), F_TO | F_BUSY);
        tick();
        chk("to_idle", flags(), 32'h0);
        chk("to_latency", last_latency, 32'd0);
`else
        // No timeout: WAIT persists, counter saturates at 255
        op_valid = 1'b1; op_div = 1'b0;
        tick();
        op_valid = 1'b0;
        tick();
        for (int i = 2; i <= 300; i++) begin
            tick();
            if (i == 65 || i == 200 || i == 300) chk($sformatf("nto_wait%0d", i), flags(), F_BUSY);
        end
        mult_fim = 1'b1;
        tick();
        chk("sat_write", flags(), F_HW | F_LW | F_BUSY);
        mult_fim = 1'b0;
        tick();
        chk("sat_latency", last_latency, 32'd255);
        tick();
        chk("sat_idle", flags(), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
